// File: rtl/sirv_cmp_timer_pkg.sv
// sirv_cmp_timer_pkg: shared widths and helpers for the compare timer
package sirv_cmp_timer_pkg;
  localparam int CNT_W = 32;
  localparam int PRE_W = 16;
  localparam int SCALE_W = 4;
  function automatic logic [PRE_W-1:0] scale_mask(input logic [SCALE_W-1:0] s);
    return (PRE_W'(1) << s) - PRE_W'(1);
  endfunction
endpackage

// File: rtl/sirv_cmp_timer_if.sv
// sirv_cmp_timer_if: configuration, load/clear strobes and status of the compare timer
interface sirv_cmp_timer_if;
  import sirv_cmp_timer_pkg::*;
  logic cfg_en;
  logic [SCALE_W-1:0] cfg_scale;
  logic cfg_zerocmp;
  logic [CNT_W-1:0] cfg_cmp;
  logic cnt_wr_en;
  logic [CNT_W-1:0] cnt_wr_data;
  logic ip_clr;
  logic [CNT_W-1:0] cnt;
  logic ip;
  logic irq_pulse;
  modport master (
    output cfg_en, cfg_scale, cfg_zerocmp, cfg_cmp, cnt_wr_en, cnt_wr_data, ip_clr,
    input cnt, ip, irq_pulse
  );
  modport slave (
    input cfg_en, cfg_scale, cfg_zerocmp, cfg_cmp, cnt_wr_en, cnt_wr_data, ip_clr,
    output cnt, ip, irq_pulse
  );
endinterface

// File: rtl/sirv_cmp_timer_prescale.sv
// sirv_cmp_timer_prescale: free-running prescaler that ticks when it reaches 2^scale-1
module sirv_cmp_timer_prescale
  import sirv_cmp_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [SCALE_W-1:0] scale,
  input  logic               clr,
  output logic               tick
);
  logic [PRE_W-1:0] pre, pre_nxt;
  // exact equality only: after a scale decrease pre runs on and wraps before ticking again
  assign tick = en && (pre == scale_mask(scale));
  assign pre_nxt = (clr || tick) ? '0 : pre + PRE_W'(1);
  sirv_gnrl_dfflr #(.DW(PRE_W)) u_pre (
    .clk(clk), .rst_n(rst_n), .lden(clr || en), .dnxt(pre_nxt), .qout(pre)
  );
endmodule

// File: rtl/sirv_gnrl_dfflr.sv
// sirv_gnrl_dfflr: general load-enabled flop with asynchronous active-low reset to zero
module sirv_gnrl_dfflr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lden,
  input  logic [DW-1:0] dnxt,
  output logic [DW-1:0] qout
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) qout <= '0;
    else if (lden) qout <= dnxt;
endmodule

// File: rtl/sirv_cmp_timer.sv
// sirv_cmp_timer: prescaled 32-bit counter with compare, sticky pending flag and edge irq
module sirv_cmp_timer
  import sirv_cmp_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  sirv_cmp_timer_if.slave  bus
);
  logic tick, match, ip, ip_nxt, irq;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  sirv_cmp_timer_prescale u_prescale (
    .clk(clk), .rst_n(rst_n), .en(bus.cfg_en), .scale(bus.cfg_scale),
    .clr(bus.cnt_wr_en), .tick(tick)
  );
  assign match = cnt >= bus.cfg_cmp;
  // software load beats both the increment and the zerocmp clear
  assign cnt_nxt = bus.cnt_wr_en ? bus.cnt_wr_data
                 : (bus.cfg_zerocmp && match) ? '0
                 : cnt + CNT_W'(1);
  assign ip_nxt = match || (ip && !bus.ip_clr);
  sirv_gnrl_dfflr #(.DW(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .lden(bus.cnt_wr_en || tick), .dnxt(cnt_nxt), .qout(cnt)
  );
  sirv_gnrl_dfflr #(.DW(1)) u_ip (
    .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(ip_nxt), .qout(ip)
  );
  // registered alongside ip so the pulse lines up with the cycle ip first reads 1
  sirv_gnrl_dfflr #(.DW(1)) u_irq (
    .clk(clk), .rst_n(rst_n), .lden(1'b1), .dnxt(ip_nxt && !ip), .qout(irq)
  );
  assign bus.cnt = cnt;
  assign bus.ip = ip;
  assign bus.irq_pulse = irq;
endmodule
